// File: rtl/sin_table.sv
// Registered 256-entry sine ROM (offset binary, 1..255) for DDS phase lookup.
// Stores one quarter wave (0..64) and folds the phase index and sign to cover a full period.
module sin_table (
    input  logic       clk,
    input  logic       rst,
    input  logic       rd,
    input  logic [7:0] addr,
    input  logic [7:0] d_in,
    output logic [7:0] d_out
);

    // round(127*sin(pi*i/128)) for i = 0..64
    function automatic logic [6:0] quarter(input logic [6:0] i);
        case (i)
            7'd0:  quarter = 7'd0;    7'd1:  quarter = 7'd3;    7'd2:  quarter = 7'd6;
            7'd3:  quarter = 7'd9;    7'd4:  quarter = 7'd12;   7'd5:  quarter = 7'd16;
            7'd6:  quarter = 7'd19;   7'd7:  quarter = 7'd22;   7'd8:  quarter = 7'd25;
            7'd9:  quarter = 7'd28;   7'd10: quarter = 7'd31;   7'd11: quarter = 7'd34;
            7'd12: quarter = 7'd37;   7'd13: quarter = 7'd40;   7'd14: quarter = 7'd43;
            7'd15: quarter = 7'd46;   7'd16: quarter = 7'd49;   7'd17: quarter = 7'd51;
            7'd18: quarter = 7'd54;   7'd19: quarter = 7'd57;   7'd20: quarter = 7'd60;
            7'd21: quarter = 7'd63;   7'd22: quarter = 7'd65;   7'd23: quarter = 7'd68;
            7'd24: quarter = 7'd71;   7'd25: quarter = 7'd73;   7'd26: quarter = 7'd76;
            7'd27: quarter = 7'd78;   7'd28: quarter = 7'd81;   7'd29: quarter = 7'd83;
            7'd30: quarter = 7'd85;   7'd31: quarter = 7'd88;   7'd32: quarter = 7'd90;
            7'd33: quarter = 7'd92;   7'd34: quarter = 7'd94;   7'd35: quarter = 7'd96;
            7'd36: quarter = 7'd98;   7'd37: quarter = 7'd100;  7'd38: quarter = 7'd102;
            7'd39: quarter = 7'd104;  7'd40: quarter = 7'd106;  7'd41: quarter = 7'd107;
            7'd42: quarter = 7'd109;  7'd43: quarter = 7'd111;  7'd44: quarter = 7'd112;
            7'd45: quarter = 7'd113;  7'd46: quarter = 7'd115;  7'd47: quarter = 7'd116;
            7'd48: quarter = 7'd117;  7'd49: quarter = 7'd118;  7'd50: quarter = 7'd120;
            7'd51: quarter = 7'd121;  7'd52: quarter = 7'd122;  7'd53: quarter = 7'd122;
            7'd54: quarter = 7'd123;  7'd55: quarter = 7'd124;  7'd56: quarter = 7'd125;
            7'd57: quarter = 7'd125;  7'd58: quarter = 7'd126;  7'd59: quarter = 7'd126;
            7'd60: quarter = 7'd126;  7'd61: quarter = 7'd127;  7'd62: quarter = 7'd127;
            7'd63: quarter = 7'd127;  7'd64: quarter = 7'd127;
            default: quarter = 7'd127;
        endcase
    endfunction

    logic [6:0] q_idx;
    logic [6:0] q_mag;
    logic [7:0] sample;

    // d_in exists only for RAM-socket compatibility
    logic unused_d_in;
    assign unused_d_in = ^d_in;

    // addr[6] mirrors the quarter, addr[7] selects the negative half-period
    always_comb begin
        q_idx  = addr[6] ? (7'd64 - {1'b0, addr[5:0]}) : {1'b0, addr[5:0]};
        q_mag  = quarter(q_idx);
        sample = addr[7] ? (8'd128 - {1'b0, q_mag}) : (8'd128 + {1'b0, q_mag});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            d_out <= 8'h00;
        else if (rd)
            d_out <= sample;
    end

endmodule

// File: tb/tb_sin_table.sv
// Scoreboard bench for sin_table: stimulus queues the expected sample per edge,
// a monitor pops and compares just after each rising edge.
module tb_sin_table;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rd = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] d_in = 8'h00;
    logic [7:0] d_out;

    sin_table dut (
        .clk  (clk),
        .rst  (rst),
        .rd   (rd),
        .addr (addr),
        .d_in (d_in),
        .d_out(d_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       exp;
        int       a;
        bit       sweep;
        string    name;
    } sb_t;

    sb_t sb[$];
    int  n_checks = 0;
    int  n_fail = 0;
    int  obs[256];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_t(input int a);
        real v;
        v = 128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * a / 256.0);
        return int'($floor(v + 0.5));
    endfunction

    // Drive one edge's worth of inputs and queue the value d_out must show after it.
    task automatic cycle(input logic r, input logic e, input int a, input int exp,
                         input bit sw, input string name);
        sb_t t;
        @(negedge clk);
        rst  = r;
        rd   = e;
        addr = a[7:0];
        d_in = 8'($urandom);
        t.exp = exp;
        t.a = a;
        t.sweep = sw;
        t.name = name;
        sb.push_back(t);
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #2;
        end
        check("drain", sb.size(), 0);
    endtask

    initial begin : monitor
        sb_t t;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                t = sb.pop_front();
                check(t.name, int'(d_out), t.exp);
                if (t.sweep) obs[t.a] = int'(d_out);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        #1 rst = 1'b1;
        #1 check("reset_state", int'(d_out), 0);

        cycle(1, 1, 5, 0, 0, "rst_hold_rd0");
        cycle(1, 1, 9, 0, 0, "rst_hold_rd1");
        cycle(0, 0, 0, 0, 0, "hold_after_reset");

        cycle(0, 1, 64, 255, 0, "latency_64");
        cycle(0, 1, 192, 1, 0, "latency_192");

        cycle(0, 1, 32, 218, 0, "hold_load_32");
        cycle(0, 0, 0, 218, 0, "hold_a0");
        cycle(0, 0, 100, 218, 0, "hold_a100");
        cycle(0, 0, 200, 218, 0, "hold_a200");

        cycle(0, 1, 0, 128, 0, "wr_imm_0");
        cycle(0, 1, 16, 177, 0, "wr_imm_16");
        cycle(0, 1, 128, 128, 0, "wr_imm_128");
        cycle(0, 1, 160, 38, 0, "wr_imm_160");
        cycle(0, 1, 224, 38, 0, "wr_imm_224");

        for (int a = 0; a < 256; a++)
            cycle(0, 1, a, ref_t(a), 1, $sformatf("sweep_%0d", a));
        cycle(0, 1, 0, 128, 0, "sweep_wrap_0");
        cycle(0, 0, 0, 128, 0, "sweep_idle");
        drain();

        check("key_96", obs[96], 218);
        check("key_192", obs[192], 1);
        for (int a = 0; a < 128; a++)
            check($sformatf("sym_half_%0d", a), obs[a] + obs[a + 128], 256);
        for (int k = 1; k < 64; k++)
            check($sformatf("sym_mirror_%0d", k), obs[64 + k], obs[64 - k]);

        cycle(0, 1, 32, 218, 0, "pre_rst_load");
        cycle(0, 0, 0, 218, 0, "pre_rst_hold");
        drain();
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check("async_reset", int'(d_out), 0);
        cycle(1, 1, 32, 0, 0, "rst_rd1_a");
        cycle(1, 1, 64, 0, 0, "rst_rd1_b");

        cycle(0, 1, 96, 218, 0, "rst_release_96");
        cycle(0, 0, 0, 218, 0, "post_release_hold");
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sin_table.md
Name: sin_table

Overview:
- Synchronous, read-only 256-entry sine lookup table: 8-bit phase address in, 8-bit unsigned offset-binary sine sample out.
- Used as the waveform ROM behind a phase accumulator (DDS / tone generator).
- Keeps a RAM-style port set (d_in present) so it drops into sockets built for the team's single-port RAM, but it has no write path.

Parameters:
- None. Address width is fixed at 8 (256 entries). Data width is fixed at 8.

Ports:
- clk    input   1  Rising-edge clock.
- rst    input   1  Asynchronous, active-high reset.
- rd     input   1  Read enable; sampled on the rising clk edge.
- addr   input   8  Phase index 0..255, one full sine period (2π·addr/256).
- d_in   input   8  Unused; ignored in every state. Kept for RAM-socket compatibility.
- d_out  output  8  Registered table sample.

Behaviour:
- Table contents:
  - T[a] = round(128 + 127·sin(2π·a/256)) for a = 0..255.
  - Rounding is half away from zero. Range is 1..255.
  - Key entries: T[0]=128, T[16]=177, T[32]=218, T[64]=255, T[96]=218, T[128]=128, T[160]=38, T[192]=1, T[224]=38.
- Symmetry: T[a] + T[(a+128) mod 256] = 256 for every a, and T[64+k] = T[64−k].
  - The implementation may store a full 256-entry constant table or a quarter-wave table with index/sign folding.
  - Output must be bit-identical to T either way.
- Reset: while rst=1, d_out = 8'h00. It is asserted asynchronously, without waiting for clk. This applies mid-operation too.
- Read timing:
  - On a rising clk edge with rst=0 and rd=1: d_out <= T[addr].
  - Latency is 1 clock. The value is valid after the edge and stays stable for the whole following cycle.
- Hold: on a rising edge with rd=0, d_out keeps its previous value, including 8'h00 after reset.
- Back-to-back reads: one new address per cycle, full throughput, no bubbles.
- Address changes between edges have no effect on d_out until the next enabled edge. There is no combinational path from addr to d_out.
- No write: any value on d_in, with any rd value, never changes table contents or d_out.
- Reset release: the first rising edge after rst falls is a normal edge. If rd=1 on that edge, d_out = T[addr].
- X-safety: addr and rd are assumed driven whenever rd=1. No other inputs influence the output.
- Storage: constant logic only (case ROM or initialized constant array). No writable storage, no initialization-file dependency.

Test Plan:
- Reset: assert rst=1 mid-cycle with d_out=218 -> d_out becomes 0 immediately. It stays 0 across edges while rst=1, even with rd=1.
- Read latency: rst=0, rd=1, addr=64 at edge N -> d_out=255 after edge N. Then addr=192 at edge N+1 -> d_out=1 after edge N+1.
- Hold: read addr=32 (d_out=218), then rd=0 and sweep addr through 0, 100, 200 over 3 edges -> d_out stays 218.
- Write immunity: drive random d_in every cycle while reading addr=0,16,128,160,224 -> d_out = 128, 177, 128, 38, 38.
- Full sweep: rd=1, addr incrementing 0..255, then wrap to 0 -> each d_out equals T[addr of the previous edge]. Check against a reference model round(128+127·sin(2πa/256)), plus the symmetry checks T[a]+T[a+128]=256 and T[64+k]=T[64−k]. After the wrap, addr=0 gives 128 again.
- Reset release: deassert rst between edges with rd=1, addr=96 -> d_out=218 after the first subsequent edge.
